bit_index_serializer: RTL and testbench
=======================================

BIT_INDEX_SERIALIZER -- requirements
Module: bit_index_serializer

Interface
REQ-001 Parameter WIDTH, default 32: width of the input bit vector; the block SHALL support WIDTH values 2, 4, 8, 16 and 32.
REQ-002 Parameter IDX_W, default 5: index width; it SHALL equal log2(WIDTH).
REQ-003 clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 in_vec  input  WIDTH  bit vector to serialize (e.g. ready or writeback mask).
REQ-006 in_valid  input  1  in_vec is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_vec this cycle.
REQ-008 out_idx  output  IDX_W  binary index of the currently presented set bit.
REQ-009 out_valid  output  1  out_idx is valid.
REQ-010 out_ready  input  1  consumer takes out_idx this cycle.
REQ-011 out_last  output  1  out_idx is the final set bit of its vector; present only when BIS_LAST_EN is defined (REQ-029).

Function
REQ-012 States: IDLE and DRAIN; one WIDTH-bit register "pending".
REQ-013 Input handshake: a vector is accepted when in_valid && in_ready; output handshake: an index is consumed when out_valid && out_ready.
REQ-014 IDLE: in_ready=1, out_valid=0.
REQ-015 IDLE, accept with in_vec!=0: pending<=in_vec; next state DRAIN.
REQ-016 Accept with in_vec==0: vector consumed and dropped, no index emitted, state IDLE.
REQ-017 DRAIN: out_valid=1; out_idx = index of the lowest set bit of pending, combinational from the pending register.
REQ-018 Latency: the first index SHALL be valid on the cycle after acceptance.
REQ-019 DRAIN, consume: the presented bit SHALL be cleared in pending; remaining bits SHALL be emitted in ascending index order, one per handshake.
REQ-020 DRAIN, consume of the last set bit: in_ready=1 in that same cycle (combinational: DRAIN && out_ready && popcount(pending)==1).
  - No accept that cycle: next state IDLE.
  - Simultaneous accept, nonzero vector: pending<=in_vec; state stays DRAIN.
  - Simultaneous accept, zero vector: next state IDLE.
REQ-021 DRAIN otherwise: in_ready=0; in_vec SHALL be ignored.
REQ-022 Backpressure: while out_valid && !out_ready, out_idx, out_last and pending SHALL hold stable.
REQ-023 in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 Throughput: one index per cycle, with zero bubble between consecutive vectors.

Reset
REQ-025 With reset_n=0 at a rising edge: state<=IDLE and pending<=0.
REQ-026 Output values after reset: out_valid=0, out_idx=0, out_last=0, in_ready=1.
REQ-027 Reset asserted mid-DRAIN SHALL discard all pending bits; no further index from that vector SHALL appear.
REQ-028 reset_n SHALL take priority over any simultaneous handshake.

Configuration
REQ-029 Macro BIS_LAST_EN:
  - Defined: out_last port exists; out_last = out_valid && popcount(pending)==1.
  - Undefined: out_last port absent; all other behaviour identical.

Structure
REQ-030 Shared package bis_pkg SHALL hold the state enum (BIS_IDLE, BIS_DRAIN) and the default constants WIDTH=32 and IDX_W=5.
REQ-031 Sub-module lsb_index_encoder: combinational WIDTH-to-IDX_W lowest-set-bit encoder with a single-bit flag; this is the inverse of the team's one-hot decoder.
REQ-032 The single-bit flag (exactly one bit set) SHALL be shared by REQ-020 and REQ-029.

Verification
REQ-033 in_vec=0x8000_0001, out_ready=1 -> out_idx 0 then 31 on consecutive cycles; out_last=1 only with 31; then IDLE.
REQ-034 in_vec=0x0000_0000 accepted -> out_valid stays 0; in_ready stays 1.
REQ-035 in_vec=0x0000_0014, out_ready=0 for 3 cycles -> out_idx=2 held stable for 3 cycles; then 2, 4 on release.
REQ-036 in_vec=0x10, with 0xFFFF_FFFF offered during the pop of index 4 -> indices 4, 0, 1, ..., 31 with no idle cycle; 33 handshakes total.
REQ-037 in_vec=0xF0, reset_n=0 after 2 pops -> next cycle out_valid=0, in_ready=1; indices 6 and 7 never emitted.
REQ-038 Random vectors with random out_ready -> emitted index set equals the set bits of each vector, in ascending order, with no loss or duplicates.

Source files
------------

// File: rtl/bis_pkg.sv
// Shared types and default sizing for the bit-index serializer.
// Optional out_last port is enabled by defining BIS_LAST_EN.
package bis_pkg;

  typedef enum logic {
    BIS_IDLE  = 1'b0,
    BIS_DRAIN = 1'b1
  } bis_state_t;

  localparam int BIS_WIDTH = 32;
  localparam int BIS_IDX_W = 5;

endpackage

// File: rtl/bit_index_serializer_lsb_index_encoder.sv
// Combinational lowest-set-bit encoder: binary index of the lowest set bit
// plus a flag that is high when exactly one bit of the vector is set.
module lsb_index_encoder
  import bis_pkg::*;
#(
  parameter int WIDTH = BIS_WIDTH,
  parameter int IDX_W = BIS_IDX_W
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]             iso;
  logic [WIDTH-1:0]             rest;
  logic [IDX_W-1:0][WIDTH-1:0]  sel;

  // Two's-complement trick isolates the lowest set bit as a one-hot vector.
  assign iso    = vec & (~vec + ONE);
  assign rest   = vec & (vec - ONE);
  assign single = (vec != '0) && (rest == '0);

  genvar gi, gj;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_idx_bit
      for (gj = 0; gj < WIDTH; gj++) begin : g_pos
        if (((gj >> gi) & 1) == 1) begin : g_hit
          assign sel[gi][gj] = iso[gj];
        end else begin : g_miss
          assign sel[gi][gj] = 1'b0;
        end
      end
      assign idx[gi] = |sel[gi];
    end
  endgenerate

endmodule

// File: rtl/bit_index_serializer.sv
// Serializes the set bits of an accepted vector into ascending binary indices.
// Define BIS_LAST_EN to add the out_last port.
module bit_index_serializer
  import bis_pkg::*;
#(
  parameter int WIDTH = BIS_WIDTH,
  parameter int IDX_W = BIS_IDX_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
`ifdef BIS_LAST_EN
  output logic             out_last,
`endif
  input  logic             out_ready
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  bis_state_t       state_reg;
  bis_state_t       state_next;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] pending_next;
  logic             single;

  lsb_index_encoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_encoder (
    .vec    (pending_reg),
    .idx    (out_idx),
    .single (single)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= BIS_IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state_reg)
      BIS_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (in_vec != '0)) begin
          pending_next = in_vec;
          state_next   = BIS_DRAIN;
        end
      end
      BIS_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Clearing the lowest set bit drops exactly the index just consumed.
          pending_next = pending_reg & (pending_reg - ONE);
          if (single) begin
            in_ready = 1'b1;
            if (in_valid && (in_vec != '0)) begin
              pending_next = in_vec;
            end else begin
              state_next = BIS_IDLE;
            end
          end
        end
      end
      default: begin
        state_next   = BIS_IDLE;
        pending_next = '0;
      end
    endcase
  end

`ifdef BIS_LAST_EN
  assign out_last = out_valid && single;
`endif

endmodule

// File: tb/tb_bit_index_serializer.sv
// Directed and randomized checks for bit_index_serializer (default 32-bit build).
module tb_bit_index_serializer;

  logic        clock;
  logic        reset_n;
  logic [31:0] in_vec;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
`ifdef BIS_LAST_EN
  logic        out_last;
`endif

  int tests;
  int fails;

  bit_index_serializer #(.WIDTH(32), .IDX_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_valid (out_valid),
`ifdef BIS_LAST_EN
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_last(input string tag, input logic exp);
`ifdef BIS_LAST_EN
    chk(tag, {31'd0, out_last}, {31'd0, exp});
`endif
  endtask

  logic [31:0] v;
  int          exp_q[$];
  int          k;
  int          cyc;
  int          pops;

  initial begin
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    in_vec    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_last("rst_out_last", 1'b0);
    reset_n = 1'b1;
    tick();

    // Two bits at the extreme ends, consumer always ready
    $display("[TB] vec=80000001 ready=1");
    in_vec = 32'h8000_0001; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("a_in_ready_idle", in_ready, 1);
    chk("a_out_valid_idle", out_valid, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("a_valid0", out_valid, 1);
    chk("a_idx0", out_idx, 0);
    chk("a_in_ready0", in_ready, 0);
    chk_last("a_last0", 1'b0);
    tick();
    chk("a_valid1", out_valid, 1);
    chk("a_idx1", out_idx, 31);
    chk("a_in_ready1", in_ready, 1);
    chk_last("a_last1", 1'b1);
    tick();
    chk("a_idle_valid", out_valid, 0);
    chk("a_idle_ready", in_ready, 1);

    // Zero vector is swallowed
    $display("[TB] vec=00000000");
    in_vec = 32'h0; in_valid = 1'b1;
    #1;
    chk("z_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("z_out_valid", out_valid, 0);
    chk("z_in_ready_after", in_ready, 1);
    chk("z_out_idx", out_idx, 0);

    // Backpressure hold; input offered during hold must be ignored
    $display("[TB] vec=00000014 with backpressure");
    in_vec = 32'h14; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_vec = 32'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b_hold_valid", out_valid, 1);
      chk("b_hold_idx", out_idx, 2);
      chk("b_hold_in_ready", in_ready, 0);
      chk_last("b_hold_last", 1'b0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("b_idx2", out_idx, 2);
    tick();
    chk("b_idx4", out_idx, 4);
    chk("b_in_ready4", in_ready, 1);
    chk_last("b_last4", 1'b1);
    tick();
    chk("b_idle", out_valid, 0);

    // Back-to-back vectors with no bubble
    $display("[TB] vec=00000010 then FFFFFFFF");
    pops = 0;
    in_vec = 32'h10; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_vec = 32'hFFFF_FFFF;
    #1;
    chk("c_in_ready", in_ready, 1);
    chk("c_idx4", out_idx, 4);
    chk_last("c_last4", 1'b1);
    if (out_valid && out_ready) pops++;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("c_valid", out_valid, 1);
      chk("c_idx", out_idx, i);
      chk_last("c_last", (i == 31));
      if (out_valid && out_ready) pops++;
      tick();
    end
    chk("c_handshakes", pops, 33);
    chk("c_idle", out_valid, 0);

    // Reset in the middle of a drain
    $display("[TB] vec=000000F0 reset mid-drain");
    in_vec = 32'hF0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("d_idx4", out_idx, 4);
    tick();
    chk("d_idx5", out_idx, 5);
    tick();
    chk("d_idx6_pre", out_idx, 6);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("d_rst_valid", out_valid, 0);
    chk("d_rst_ready", in_ready, 1);
    chk("d_rst_idx", out_idx, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("d_post_valid", out_valid, 0);
    end

    // Random vectors with random consumer stalls
    for (int n = 0; n < 16; n++) begin
      v = $urandom;
      if (n == 3) v = 32'h0;
      if (n == 7) v = 32'h4000_0000;
      $display("[TB] random vec=%08h", v);
      for (int i = 0; i < 32; i++) if (v[i]) exp_q.push_back(i);
      in_vec = v; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk("r_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      k = 0; cyc = 0;
      while (k < exp_q.size() && cyc < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        chk("r_valid", out_valid, 1);
        if (out_valid && out_ready) begin
          chk("r_idx", out_idx, exp_q[k]);
          k++;
        end
        tick();
        cyc++;
      end
      chk("r_count", k, exp_q.size());
      out_ready = 1'b0;
      #1;
      chk("r_idle", out_valid, 0);
      exp_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
